// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program counter with relative/absolute branching, a
//                return-address stack for CALL/RET, and an optional sticky
//                watchdog that freezes the unit once the PC reaches a limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4,
    parameter int PC_LIMIT  = 8,
    parameter int HALT_EN   = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      phase,
    input  logic                            stall,
    input  logic [2:0]                      op,
    input  logic [ADDR_W-1:0]               offset,
    input  logic [ADDR_W-1:0]               target,
    output logic [ADDR_W-1:0]               pc,
    output logic                            halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
    output logic                            ras_ovf,
    output logic                            ras_unf
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    // A single-entry stack still needs a one-bit index.
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RAS_DEPTH);
    localparam logic [31:0]      C_LIMIT = 32'(PC_LIMIT);

    localparam logic [2:0] C_OP_BR_REL = 3'd1;
    localparam logic [2:0] C_OP_JMP    = 3'd2;
    localparam logic [2:0] C_OP_CALL   = 3'd3;
    localparam logic [2:0] C_OP_RET    = 3'd4;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_ovf;
    logic                w_ovf_next;
    logic                r_unf;
    logic                w_unf_next;
    logic                w_update;
    logic                w_push;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_top_idx;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];

    assign w_update   = (phase == 2'b11) && !stall && (r_state == S_RUN);
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_push_idx = IDX_W'(r_count);
    assign w_top_idx  = IDX_W'(r_count - CNT_W'(1));

    // Next-state decode: PC selection, stack bookkeeping and watchdog entry.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;
        if (w_update) begin
            case (op)
                C_OP_BR_REL: w_pc_next = r_pc + offset;
                C_OP_JMP:    w_pc_next = target;
                C_OP_CALL: begin
                    w_pc_next = target;
                    if (r_count < C_DEPTH) begin
                        w_push       = 1'b1;
                        w_count_next = r_count + CNT_W'(1);
                    end else begin
                        w_ovf_next   = 1'b1;
                    end
                end
                C_OP_RET: begin
                    if (r_count != '0) begin
                        w_pc_next    = r_ras[w_top_idx];
                        w_count_next = r_count - CNT_W'(1);
                    end else begin
                        w_pc_next    = w_pc_inc;
                        w_unf_next   = 1'b1;
                    end
                end
                default:     w_pc_next = w_pc_inc;
            endcase
            if ((HALT_EN != 0) && (32'(w_pc_next) >= C_LIMIT)) begin
                w_state_next = S_HALT;
            end
        end
    end

    // Control and PC registers; reset overrides any update at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Stack storage holds the return address; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_ras[w_push_idx] <= w_pc_inc;
        end
    end

    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign ras_count = r_count;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit. Two instances share the
//                stimulus: one with the watchdog (limit 8), one without.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] phase;
    logic       stall;
    logic [2:0] op;
    logic [7:0] offset;
    logic [7:0] target;

    logic [7:0] pc_h, pc_n;
    logic       halted_h, halted_n;
    logic [2:0] cnt_h, cnt_n;
    logic       ovf_h, ovf_n, unf_h, unf_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit #(.ADDR_W(8), .RAS_DEPTH(4), .PC_LIMIT(8), .HALT_EN(1)) dut_h (
        .clk(clk), .reset(reset), .phase(phase), .stall(stall), .op(op),
        .offset(offset), .target(target), .pc(pc_h), .halted(halted_h),
        .ras_count(cnt_h), .ras_ovf(ovf_h), .ras_unf(unf_h)
    );

    pc_unit #(.ADDR_W(8), .RAS_DEPTH(4), .PC_LIMIT(8), .HALT_EN(0)) dut_n (
        .clk(clk), .reset(reset), .phase(phase), .stall(stall), .op(op),
        .offset(offset), .target(target), .pc(pc_n), .halted(halted_n),
        .ras_count(cnt_n), .ras_ovf(ovf_n), .ras_unf(unf_n)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int  m_pc   [2];
    int  m_cnt  [2];
    int  m_stk  [2][16];
    bit  m_halt [2];
    bit  m_ovf  [2];
    bit  m_unf  [2];
    bit  m_valid = 1'b0;

    task automatic model_step(input int k, input bit hen);
        int np;
        if (reset) begin
            m_pc[k] = 0; m_cnt[k] = 0; m_halt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
        end else if (phase == 2'd3 && !stall && !m_halt[k]) begin
            case (op)
                3'd1: np = (m_pc[k] + int'($signed(offset))) & 255;
                3'd2: np = int'(target);
                3'd3: begin
                    np = int'(target);
                    if (m_cnt[k] < 4) begin
                        m_stk[k][m_cnt[k]] = (m_pc[k] + 1) & 255;
                        m_cnt[k]++;
                    end else m_ovf[k] = 1;
                end
                3'd4: begin
                    if (m_cnt[k] > 0) begin
                        m_cnt[k]--;
                        np = m_stk[k][m_cnt[k]];
                    end else begin
                        m_unf[k] = 1;
                        np = (m_pc[k] + 1) & 255;
                    end
                end
                default: np = (m_pc[k] + 1) & 255;
            endcase
            if (hen && np >= 8) m_halt[k] = 1;
            m_pc[k] = np;
        end
    endtask

    // Compare process: advance the model on every edge, check just after it.
    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        if (reset) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            chk("model_pc_h",     int'(pc_h),     m_pc[0]);
            chk("model_halted_h", int'(halted_h), int'(m_halt[0]));
            chk("model_cnt_h",    int'(cnt_h),    m_cnt[0]);
            chk("model_ovf_h",    int'(ovf_h),    int'(m_ovf[0]));
            chk("model_unf_h",    int'(unf_h),    int'(m_unf[0]));
            chk("model_pc_n",     int'(pc_n),     m_pc[1]);
            chk("model_halted_n", int'(halted_n), int'(m_halt[1]));
            chk("model_cnt_n",    int'(cnt_n),    m_cnt[1]);
            chk("model_ovf_n",    int'(ovf_n),    int'(m_ovf[1]));
            chk("model_unf_n",    int'(unf_n),    int'(m_unf[1]));
        end
    end

    // Apply one set of inputs for exactly one rising edge.
    task automatic step(input bit r, input logic [1:0] ph, input bit st,
                        input logic [2:0] o, input logic [7:0] off, input logic [7:0] tgt);
        @(negedge clk);
        reset = r; phase = ph; stall = st; op = o; offset = off; target = tgt;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b1, 2'd3, 1'b0, 3'd2, 8'h00, 8'h44);
    endtask

    initial begin
        reset = 1'b1; phase = 2'd0; stall = 1'b0; op = 3'd0; offset = '0; target = '0;
        do_reset();
        chk("reset_pc",  int'(pc_h), 0);
        chk("reset_cnt", int'(cnt_h), 0);
        chk("reset_halted", int'(halted_h), 0);

        // Sequential stepping and a non-update phase.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
            chk("seq_pc", int'(pc_h), i);
        end
        step(1'b0, 2'd1, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("phase1_hold", int'(pc_h), 4);

        // Negative branch and wrap on the non-halting instance.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd3, 1'b0, 3'd1, 8'hFE, 8'h00);
        chk("br_rel_back", int'(pc_n), 1);
        step(1'b0, 2'd3, 1'b0, 3'd2, 8'h00, 8'hFF);
        chk("jmp_ff", int'(pc_n), 255);
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("wrap_pc", int'(pc_n), 0);
        chk("no_halt_when_disabled", int'(halted_n), 0);

        // Call and return.
        do_reset();
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd3, 1'b0, 3'd3, 8'h00, 8'h05);
        chk("call_pc", int'(pc_n), 5);
        chk("call_cnt", int'(cnt_n), 1);
        step(1'b0, 2'd3, 1'b0, 3'd4, 8'h00, 8'h00);
        chk("ret_pc", int'(pc_n), 3);
        chk("ret_cnt", int'(cnt_n), 0);

        // Stack overflow then underflow: returns land at 4,3,2,1 then 2.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b0, 2'd3, 1'b0, 3'd3, 8'h00, 8'(i));
        chk("ovf_cnt", int'(cnt_n), 4);
        chk("ovf_flag", int'(ovf_n), 1);
        chk("ovf_pc", int'(pc_n), 5);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd3, 1'b0, 3'd4, 8'h00, 8'h00);
            chk("pop_pc", int'(pc_n), 4 - i);
        end
        chk("unf_before", int'(unf_n), 0);
        step(1'b0, 2'd3, 1'b0, 3'd4, 8'h00, 8'h00);
        chk("unf_flag", int'(unf_n), 1);
        chk("unf_pc", int'(pc_n), 2);

        // Watchdog.
        do_reset();
        step(1'b0, 2'd3, 1'b0, 3'd2, 8'h00, 8'h07);
        chk("pre_halt", int'(halted_h), 0);
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("halt_pc", int'(pc_h), 8);
        chk("halt_flag", int'(halted_h), 1);
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd3, 1'b0, 3'd3, 8'h00, 8'h01);
        chk("halt_frozen_pc", int'(pc_h), 8);
        chk("halt_frozen_cnt", int'(cnt_h), 0);
        do_reset();
        chk("halt_reset_pc", int'(pc_h), 0);
        chk("halt_reset_flag", int'(halted_h), 0);

        // Stall and reset priority.
        step(1'b0, 2'd3, 1'b0, 3'd0, 8'h00, 8'h00);
        step(1'b0, 2'd3, 1'b1, 3'd2, 8'h00, 8'h06);
        chk("stall_hold", int'(pc_h), 1);
        step(1'b1, 2'd3, 1'b0, 3'd2, 8'h00, 8'h06);
        chk("reset_priority", int'(pc_h), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 3'($urandom_range(0, 7)),
                 8'($urandom),
                 ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
